perceptron_train_ctrl: RTL and testbench

Parametrised control FSM for the perceptron training datapath. It generalises the fixed two-input trainer to N_FEAT features and adds a valid/ready sample handshake, serial per-weight update sequencing and epoch counting. Training stops when an epoch completes with no weight update. The datapath (weight regs, y_in adder, comparator) stays external; this block only drives its load/init strobes.

---
 rtl/perceptron_pkg.sv | 25 ++
 rtl/perceptron_seq_counter.sv | 65 ++++++
 rtl/perceptron_train_ctrl.sv | 148 ++++++++++++++
 tb/tb_perceptron_train_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and defaults for the perceptron training controller.
// EPOCH_LIMIT_EN (optional) enables the epoch limit in perceptron_seq_counter.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FETCH,
        COMPUTE,
        CHECK,
        UPDATE,
        NEXT,
        DONE
    } state_t;

    localparam int DEF_N_FEAT  = 2;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_EPOCH_W = 8;

    // w_sel must also address the bias slot, which sits one past the last weight
    function automatic int selWidth(input int nFeat);
        return $clog2(nFeat + 1);
    endfunction

endpackage

// File: rtl/perceptron_seq_counter.sv
// Sample index / epoch counters with epoch-end detect and, when EPOCH_LIMIT_EN
// is defined, an epoch-limit compare (otherwise limitHit is tied low).
module perceptron_seq_counter
    import perceptron_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int EPOCH_W = DEF_EPOCH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               advance,
    input  logic [CNT_W-1:0]   nSamples,
    input  logic [EPOCH_W-1:0] maxEpochs,
    output logic [CNT_W-1:0]   sampleIdx,
    output logic [EPOCH_W-1:0] epochCnt,
    output logic               epochEnd,
    output logic               limitHit
);

    logic [CNT_W-1:0]   nReg;
    logic [EPOCH_W-1:0] epochInc;

    assign epochInc = (epochCnt == '1) ? epochCnt : epochCnt + EPOCH_W'(1);
    assign epochEnd = (sampleIdx == nReg - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sampleIdx <= '0;
            epochCnt  <= '0;
            nReg      <= '0;
        end else if (clear) begin
            sampleIdx <= '0;
            epochCnt  <= '0;
            nReg      <= nSamples;
        end else if (advance) begin
            if (epochEnd) begin
                sampleIdx <= '0;
                epochCnt  <= epochInc;
            end else begin
                sampleIdx <= sampleIdx + CNT_W'(1);
            end
        end
    end

`ifdef EPOCH_LIMIT_EN
    logic [EPOCH_W-1:0] maxReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            maxReg <= '0;
        end else if (clear) begin
            maxReg <= maxEpochs;
        end
    end

    // A limit of zero means training may run for any number of epochs
    assign limitHit = (maxReg != '0) && (epochInc == maxReg);
`else
    logic unusedMaxEpochs;
    assign unusedMaxEpochs = ^maxEpochs;
    assign limitHit        = 1'b0;
`endif

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Control FSM for the perceptron training datapath: sample handshake, serial
// weight/bias update sequencing and epoch control. Optional macro: EPOCH_LIMIT_EN.
module perceptron_train_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_FEAT  = DEF_N_FEAT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int EPOCH_W = DEF_EPOCH_W,
    parameter int SEL_W   = selWidth(N_FEAT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_samples,
    input  logic [EPOCH_W-1:0] max_epochs,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               eq_flag,
    output logic               ld_x,
    output logic               ld_t,
    output logic               ld_yin,
    output logic               init_w,
    output logic               init_b,
    output logic [N_FEAT-1:0]  ld_w,
    output logic               ld_b,
    output logic [SEL_W-1:0]   w_sel,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic [CNT_W-1:0]   sample_idx
);

    state_t             state;
    state_t             stateNext;
    logic               clean;
    logic [SEL_W-1:0]   kIdx;
    logic               cntClear;
    logic               cntAdvance;
    logic               epochEnd;
    logic               limitHit;

    perceptron_seq_counter #(
        .CNT_W   (CNT_W),
        .EPOCH_W (EPOCH_W)
    ) seqCounter (
        .clk       (clk),
        .rst       (rst),
        .clear     (cntClear),
        .advance   (cntAdvance),
        .nSamples  (n_samples),
        .maxEpochs (max_epochs),
        .sampleIdx (sample_idx),
        .epochCnt  (epoch_cnt),
        .epochEnd  (epochEnd),
        .limitHit  (limitHit)
    );

    // clean tracks whether the current epoch has needed any weight update
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clean     <= 1'b0;
            kIdx      <= '0;
            converged <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: if (start) converged <= 1'b0;
                INIT: begin
                    clean <= 1'b1;
                    kIdx  <= '0;
                    if (n_samples == '0) converged <= 1'b1;
                end
                CHECK: if (!eq_flag) begin
                    clean <= 1'b0;
                    kIdx  <= '0;
                end
                UPDATE: kIdx <= kIdx + SEL_W'(1);
                NEXT: if (epochEnd) begin
                    if (clean) converged <= 1'b1;
                    else       clean     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext    = state;
        sample_ready = 1'b0;
        ld_x         = 1'b0;
        ld_t         = 1'b0;
        ld_yin       = 1'b0;
        init_w       = 1'b0;
        init_b       = 1'b0;
        ld_w         = '0;
        ld_b         = 1'b0;
        w_sel        = '0;
        done         = 1'b0;
        cntClear     = 1'b0;
        cntAdvance   = 1'b0;
        case (state)
            IDLE: if (start) stateNext = INIT;
            INIT: begin
                init_w    = 1'b1;
                init_b    = 1'b1;
                cntClear  = 1'b1;
                stateNext = (n_samples == '0) ? DONE : FETCH;
            end
            FETCH: begin
                sample_ready = 1'b1;
                ld_x         = sample_valid;
                ld_t         = sample_valid;
                if (sample_valid) stateNext = COMPUTE;
            end
            COMPUTE: begin
                ld_yin    = 1'b1;
                stateNext = CHECK;
            end
            CHECK: stateNext = eq_flag ? NEXT : UPDATE;
            // One element per cycle: weights 0..N_FEAT-1, then the bias slot
            UPDATE: begin
                w_sel = kIdx;
                for (int i = 0; i < N_FEAT; i++) begin
                    ld_w[i] = (kIdx == SEL_W'(i));
                end
                if (kIdx == SEL_W'(N_FEAT)) begin
                    ld_b      = 1'b1;
                    stateNext = NEXT;
                end
            end
            NEXT: begin
                cntAdvance = 1'b1;
                if (epochEnd && (clean || limitHit)) stateNext = DONE;
                else                                  stateNext = FETCH;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl: directed scenarios plus
// randomized training runs scored against a per-sample timing/outcome model.
module tb_perceptron_train_ctrl;

    localparam int N_FEAT  = 2;
    localparam int CNT_W   = 16;
    localparam int EPOCH_W = 8;
    localparam int SEL_W   = $clog2(N_FEAT + 1);
`ifdef EPOCH_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic [CNT_W-1:0]   n_samples;
    logic [EPOCH_W-1:0] max_epochs;
    logic               sample_valid;
    logic               sample_ready;
    logic               eq_flag;
    logic               ld_x;
    logic               ld_t;
    logic               ld_yin;
    logic               init_w;
    logic               init_b;
    logic [N_FEAT-1:0]  ld_w;
    logic               ld_b;
    logic [SEL_W-1:0]   w_sel;
    logic               busy;
    logic               done;
    logic               converged;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic [CNT_W-1:0]   sample_idx;

    int checks = 0;
    int errors = 0;

    // errTab[e][i] = 1 means sample i of epoch e is misclassified
    bit errTab [8][8];

    perceptron_train_ctrl #(
        .N_FEAT  (N_FEAT),
        .CNT_W   (CNT_W),
        .EPOCH_W (EPOCH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_samples    (n_samples),
        .max_epochs   (max_epochs),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .eq_flag      (eq_flag),
        .ld_x         (ld_x),
        .ld_t         (ld_t),
        .ld_yin       (ld_yin),
        .init_w       (init_w),
        .init_b       (init_b),
        .ld_w         (ld_w),
        .ld_b         (ld_b),
        .w_sel        (w_sel),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .epoch_cnt    (epoch_cnt),
        .sample_idx   (sample_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit errAt(input int e, input int i);
        if (e < 8 && i < 8) return errTab[e][i];
        return 1'b0;
    endfunction

    task automatic setErrors(input bit val);
        for (int e = 0; e < 8; e++)
            for (int i = 0; i < 8; i++)
                errTab[e][i] = val;
    endtask

    // Runs one training session and compares it against the model outcome
    task automatic runTraining(input int n, input int maxEp, input string tag);
        int  expCycles;
        int  expBursts;
        int  expSamples;
        int  expEpochs;
        bit  expConv;
        int  ep;
        bit  cleanEp;
        int  doneCyc;
        int  acc;
        int  bursts;
        int  expK;
        int  ones;
        logic [N_FEAT-1:0] expW;

        expCycles  = 1;
        expBursts  = 0;
        expSamples = 0;
        expConv    = 1'b0;
        ep         = 0;
        while (1) begin
            cleanEp = 1'b1;
            for (int i = 0; i < n; i++) begin
                expCycles += 4;
                expSamples++;
                if (errAt(ep, i)) begin
                    expCycles += N_FEAT + 1;
                    expBursts++;
                    cleanEp = 1'b0;
                end
            end
            ep++;
            if (cleanEp) begin
                expConv = 1'b1;
                break;
            end
            if (LIMIT_EN && maxEp != 0 && ((ep > 255) ? 255 : ep) == maxEp) break;
        end
        expEpochs = (ep > 255) ? 255 : ep;

        @(negedge clk);
        n_samples    = CNT_W'(n);
        max_epochs   = EPOCH_W'(maxEp);
        sample_valid = 1'b1;
        eq_flag      = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;

        checks++;
        if (init_w !== 1'b1 || init_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s init: init_w=%0b init_b=%0b expected 1/1", tag, init_w, init_b);
        end

        doneCyc = -1;
        acc     = 0;
        bursts  = 0;
        expK    = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s busy: cycle %0d got %0b expected 1", tag, cyc, busy);
            end
            if (ld_x === 1'b1) begin
                checks++;
                if (sample_idx !== CNT_W'(acc % n) || epoch_cnt !== EPOCH_W'(acc / n)) begin
                    errors++;
                    $display("[TB] FAIL %s position: idx=%0d epoch=%0d expected %0d/%0d",
                             tag, sample_idx, epoch_cnt, acc % n, acc / n);
                end
                eq_flag = !errAt(acc / n, acc % n);
                acc++;
            end
            ones = $countones(ld_w) + int'(ld_b);
            if (ones != 0) begin
                checks++;
                expW = '0;
                if (expK < N_FEAT) expW[expK] = 1'b1;
                if (ones != 1 || ld_w !== expW || ld_b !== (expK == N_FEAT) || w_sel !== SEL_W'(expK)) begin
                    errors++;
                    $display("[TB] FAIL %s strobe: ld_w=%b ld_b=%b w_sel=%0d expected element %0d",
                             tag, ld_w, ld_b, w_sel, expK);
                end
                if (ld_b === 1'b1) begin
                    bursts++;
                    expK = 0;
                end else begin
                    expK++;
                end
            end
            if (done === 1'b1) begin
                doneCyc = cyc;
                break;
            end
            @(negedge clk);
        end

        checks++;
        if (doneCyc != expCycles) begin
            errors++;
            $display("[TB] FAIL %s done_cycle: got %0d expected %0d", tag, doneCyc, expCycles);
        end
        checks++;
        if (epoch_cnt !== EPOCH_W'(expEpochs)) begin
            errors++;
            $display("[TB] FAIL %s epoch_cnt: got %0d expected %0d", tag, epoch_cnt, expEpochs);
        end
        checks++;
        if (converged !== expConv) begin
            errors++;
            $display("[TB] FAIL %s converged: got %0b expected %0b", tag, converged, expConv);
        end
        checks++;
        if (bursts != expBursts || acc != expSamples) begin
            errors++;
            $display("[TB] FAIL %s counts: bursts=%0d samples=%0d expected %0d/%0d",
                     tag, bursts, acc, expBursts, expSamples);
        end

        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || converged !== expConv || epoch_cnt !== EPOCH_W'(expEpochs)) begin
            errors++;
            $display("[TB] FAIL %s idle_after: done=%0b busy=%0b conv=%0b epoch=%0d expected 0/0/%0b/%0d",
                     tag, done, busy, converged, epoch_cnt, expConv, expEpochs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, converged, sample_ready, ld_x, ld_t, ld_yin, init_w, init_b, ld_b} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0", {busy, done, converged, sample_ready,
                     ld_x, ld_t, ld_yin, init_w, init_b, ld_b});
        end
        checks++;
        if (ld_w !== '0 || epoch_cnt !== '0 || sample_idx !== '0) begin
            errors++;
            $display("[TB] FAIL reset_counts: ld_w=%b epoch=%0d idx=%0d expected 0", ld_w, epoch_cnt, sample_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_all_correct();
        setErrors(1'b0);
        runTraining(4, 0, "all_correct");
    endtask

    task automatic test_single_error();
        setErrors(1'b0);
        errTab[0][1] = 1'b1;
        runTraining(4, 0, "single_error");
    endtask

    task automatic test_epoch_limit();
        setErrors(1'b1);
        runTraining(2, 3, "epoch_limit");
    endtask

    task automatic test_stall();
        @(negedge clk);
        n_samples    = CNT_W'(1);
        sample_valid = 1'b0;
        eq_flag      = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (sample_ready !== 1'b1 || ld_x !== 1'b0 || ld_t !== 1'b0 || ld_yin !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: cycle %0d ready=%0b ld_x=%0b ld_t=%0b ld_yin=%0b expected 1/0/0/0",
                         s, sample_ready, ld_x, ld_t, ld_yin);
            end
        end
        @(negedge clk);
        sample_valid = 1'b1;
        #1;
        checks++;
        if (ld_x !== 1'b1 || ld_t !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_accept: ld_x=%0b ld_t=%0b expected 1/1", ld_x, ld_t);
        end
        @(negedge clk);
        checks++;
        if (ld_yin !== 1'b1 || sample_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_compute: ld_yin=%0b ready=%0b expected 1/0", ld_yin, sample_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || converged !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_done: done=%0b conv=%0b expected 1/1", done, converged);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_update();
        int  seenK1;
        bit  hit;
        @(negedge clk);
        n_samples    = CNT_W'(1);
        max_epochs   = '0;
        sample_valid = 1'b1;
        eq_flag      = 1'b0;
        start        = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        seenK1 = 0;
        hit    = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (ld_w[1] === 1'b1) seenK1++;
            if (seenK1 == 2) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit || epoch_cnt !== EPOCH_W'(1)) begin
            errors++;
            $display("[TB] FAIL midupd_reach: hit=%0b epoch=%0d expected 1/1", hit, epoch_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ld_w !== '0 || ld_b !== 1'b0 || busy !== 1'b0 || epoch_cnt !== '0 || converged !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midupd_reset: ld_w=%b ld_b=%0b busy=%0b epoch=%0d conv=%0b expected 0",
                     ld_w, ld_b, busy, epoch_cnt, converged);
        end
        rst = 1'b0;
        setErrors(1'b0);
        runTraining(3, 0, "restart");
    endtask

    task automatic test_zero_samples();
        int readySeen;
        int donePulses;
        @(negedge clk);
        n_samples    = '0;
        sample_valid = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        readySeen  = 0;
        donePulses = 0;
        checks++;
        if (init_w !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_init: init_w=%0b done=%0b expected 1/0", init_w, done);
        end
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (sample_ready === 1'b1) readySeen++;
            if (done === 1'b1) donePulses++;
            if (cyc == 0) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL zero_done: got %0b expected 1", done);
                end
            end
        end
        checks++;
        if (readySeen != 0 || donePulses != 1 || converged !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_summary: ready=%0d done=%0d conv=%0b busy=%0b expected 0/1/1/0",
                     readySeen, donePulses, converged, busy);
        end
    endtask

    task automatic test_random();
        int n;
        int errEpochs;
        int maxEp;
        for (int run = 0; run < 8; run++) begin
            n         = $urandom_range(1, 5);
            errEpochs = $urandom_range(0, 3);
            maxEp     = $urandom_range(0, 4);
            for (int e = 0; e < 8; e++)
                for (int i = 0; i < 8; i++)
                    errTab[e][i] = (e < errEpochs) && ($urandom_range(0, 2) == 0);
            runTraining(n, maxEp, $sformatf("random%0d", run));
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        n_samples    = '0;
        max_epochs   = '0;
        sample_valid = 1'b0;
        eq_flag      = 1'b1;
        test_reset();
        test_all_correct();
        test_single_error();
        test_epoch_limit();
        test_stall();
        test_reset_mid_update();
        test_zero_samples();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
